// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a request/ack instruction memory port and fills the IF/ID slot.
// A one-entry skid buffer parks a response while ID stalls; a redirect drops any in-flight response.
//
// state | meaning
// REQ   | request outstanding at pc
// HOLD  | response parked in skid buffer, ID stalled, no request
// DROP  | in-flight response at pc will be discarded, pendPc holds redirect target
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iHazard,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   output logic        oIMemReq,
   output logic [31:0] oIMemAddr,
   input  logic        iIMemAck,
   input  logic [31:0] iIMemData,
   output logic [31:0] oID_Instr,
   output logic [31:0] oID_PC,
   output logic [31:0] oID_PC4,
   output logic        oID_Valid
);

   typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;

   state_t      state, stateNext;
   logic [31:0] pc, pcNext;
   logic [31:0] pendPc, pendPcNext;
   logic [31:0] skidInstr, skidInstrNext;
   logic [31:0] skidPc, skidPcNext;
   logic [31:0] idInstr, idInstrNext;
   logic [31:0] idPc, idPcNext;
   logic [31:0] idPc4, idPc4Next;
   logic        idValid, idValidNext;
   logic [31:0] redirTarget;

   assign redirTarget = {iRedirectPC[31:2], 2'b00};

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state     <= REQ;
         pc        <= RESET_PC;
         pendPc    <= RESET_PC;
         skidInstr <= '0;
         skidPc    <= '0;
         idInstr   <= NOP_INSTR;
         idPc      <= '0;
         idPc4     <= '0;
         idValid   <= 1'b0;
      end else begin
         state     <= stateNext;
         pc        <= pcNext;
         pendPc    <= pendPcNext;
         skidInstr <= skidInstrNext;
         skidPc    <= skidPcNext;
         idInstr   <= idInstrNext;
         idPc      <= idPcNext;
         idPc4     <= idPc4Next;
         idValid   <= idValidNext;
      end
   end

   always_comb begin
      stateNext     = state;
      pcNext        = pc;
      pendPcNext    = pendPc;
      skidInstrNext = skidInstr;
      skidPcNext    = skidPc;
      idInstrNext   = idInstr;
      idPcNext      = idPc;
      idPc4Next     = idPc4;
      idValidNext   = idValid;

      if (iRedirect) begin
         idValidNext = 1'b0;
         idInstrNext = NOP_INSTR;
         case (state)
            REQ, DROP: begin
               if (iIMemAck) begin
                  pcNext    = redirTarget;
                  stateNext = REQ;
               end else begin
                  // old address stays on the bus until its response is swallowed
                  pendPcNext = redirTarget;
                  stateNext  = DROP;
               end
            end
            default: begin
               pcNext    = redirTarget;
               stateNext = REQ;
            end
         endcase
      end else begin
         case (state)
            REQ: begin
               if (iIMemAck) begin
                  pcNext = pc + 32'd4;
                  if (!idValid || !iHazard) begin
                     idInstrNext = iIMemData;
                     idPcNext    = pc;
                     idPc4Next   = pc + 32'd4;
                     idValidNext = 1'b1;
                  end else begin
                     skidInstrNext = iIMemData;
                     skidPcNext    = pc;
                     stateNext     = HOLD;
                  end
               end else if (!iHazard) begin
                  idValidNext = 1'b0;
                  idInstrNext = NOP_INSTR;
               end
            end
            HOLD: begin
               if (!iHazard) begin
                  idInstrNext = skidInstr;
                  idPcNext    = skidPc;
                  idPc4Next   = skidPc + 32'd4;
                  idValidNext = 1'b1;
                  stateNext   = REQ;
               end
            end
            DROP: begin
               if (iIMemAck) begin
                  pcNext    = pendPc;
                  stateNext = REQ;
               end
               if (!iHazard) begin
                  idValidNext = 1'b0;
                  idInstrNext = NOP_INSTR;
               end
            end
            default: stateNext = REQ;
         endcase
      end
   end

   assign oIMemReq  = !iRST && (state != HOLD);
   assign oIMemAddr = pc;
   assign oID_Instr = idInstr;
   assign oID_PC    = idPc;
   assign oID_PC4   = idPc4;
   assign oID_Valid = idValid;

endmodule
